// File: rtl/puck_physics_if.sv
// puck_physics_if: groups the per-frame control inputs, paddle positions and
// game outputs of puck_physics into one bundle.
//   master : drives frame_tick, serve and the paddle centres; reads the puck
//            position, scores, goal, game_over and state.
//   slave  : the physics engine side.
interface puck_physics_if;
  logic       frame_tick;
  logic       serve;
  logic [9:0] paddle_a_x, paddle_a_y;
  logic [9:0] paddle_b_x, paddle_b_y;
  logic [9:0] puck_x, puck_y;
  logic [3:0] score_a, score_b;
  logic       goal;
  logic       game_over;
  logic [1:0] state;

  modport master (
    output frame_tick, serve, paddle_a_x, paddle_a_y, paddle_b_x, paddle_b_y,
    input  puck_x, puck_y, score_a, score_b, goal, game_over, state
  );

  modport slave (
    input  frame_tick, serve, paddle_a_x, paddle_a_y, paddle_b_x, paddle_b_y,
    output puck_x, puck_y, score_a, score_b, goal, game_over, state
  );
endinterface

// File: rtl/puck_physics.sv
// puck_physics: per-frame air-hockey puck motion engine feeding vga_sync.
// On each frame_tick in PLAY the puck advances by (vx,vy), bounces off the
// top/bottom walls, bounces or scores at the left/right walls, and is
// deflected by paddle boxes. A game FSM sequences SERVE -> PLAY -> HOLD ->
// (SERVE | OVER).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : puck_physics_if.slave (frame_tick, serve, paddle centres in;
//                puck_x/puck_y, score_a/score_b, goal, game_over, state out)
// Optional feature: define PUCK_SPEEDUP_EN to add +1 to |vx| on every paddle
// hit, capped at MAX_SPEED.
module puck_physics #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int PUCK_R      = 8,
  parameter int PADDLE_R    = 16,
  parameter int SPEED       = 2,
  parameter int MAX_SPEED   = 7,
  parameter int GOAL_TOP    = 160,
  parameter int GOAL_BOT    = 319,
  parameter int HOLD_FRAMES = 60,
  parameter int WIN_SCORE   = 7
) (
  input  logic           clk,
  input  logic           rst_n,
  puck_physics_if.slave  bus
);

  typedef enum logic [1:0] {
    S_SERVE = 2'd0,
    S_PLAY  = 2'd1,
    S_HOLD  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [9:0]         CX      = 10'(SCREEN_W / 2);
  localparam logic [9:0]         CY      = 10'(SCREEN_H / 2);
  localparam logic signed [10:0] LO      = 11'(PUCK_R);
  localparam logic signed [10:0] X_HI    = 11'(SCREEN_W - 1 - PUCK_R);
  localparam logic signed [10:0] Y_HI    = 11'(SCREEN_H - 1 - PUCK_R);
  localparam logic signed [10:0] G_TOP   = 11'(GOAL_TOP);
  localparam logic signed [10:0] G_BOT   = 11'(GOAL_BOT);
  localparam logic signed [11:0] REACH   = 12'(PUCK_R + PADDLE_R);
  localparam logic signed [4:0]  SPD     = 5'(SPEED);
  localparam logic [3:0]         WIN     = 4'(WIN_SCORE);
  localparam logic [HW-1:0]      HOLD_LAST = HW'(HOLD_FRAMES - 1);
`ifdef PUCK_SPEEDUP_EN
  localparam logic signed [4:0]  VMAX    = 5'(MAX_SPEED);
`endif

  function automatic logic signed [11:0] fn_abs12(input logic signed [11:0] v);
    return v[11] ? -v : v;
  endfunction

  state_t             r_state, w_state_n;
  logic [9:0]         r_x, r_y, w_x_n, w_y_n;
  logic signed [4:0]  r_vx, r_vy, w_vx_n, w_vy_n;
  logic [3:0]         r_sa, r_sb, w_sa_n, w_sb_n;
  logic               r_dir, r_ysgn, w_dir_n, w_ysgn_n;
  logic               r_goal, w_goal_n, r_over;
  logic [HW-1:0]      r_hold, w_hold_n;

  // Motion datapath: 11-bit signed so a step past x=0 / y=0 shows up negative.
  logic signed [10:0] w_nx, w_ny, w_ny_c;
  logic signed [4:0]  w_avx, w_avy, w_vy_b, w_vmag;
  logic signed [11:0] w_dax, w_day, w_dbx, w_dby;
  logic               w_hit_a, w_hit_b, w_mouth;

  always_comb begin
    w_nx  = $signed({1'b0, r_x}) + $signed({{6{r_vx[4]}}, r_vx});
    w_ny  = $signed({1'b0, r_y}) + $signed({{6{r_vy[4]}}, r_vy});
    w_avx = r_vx[4] ? -r_vx : r_vx;
    w_avy = r_vy[4] ? -r_vy : r_vy;

    // Top/bottom walls clamp and force vy away from the wall.
    if (w_ny <= LO) begin
      w_ny_c = LO;
      w_vy_b = w_avy;
    end else if (w_ny >= Y_HI) begin
      w_ny_c = Y_HI;
      w_vy_b = -w_avy;
    end else begin
      w_ny_c = w_ny;
      w_vy_b = r_vy;
    end

    // Goal mouth is judged on the clamped y.
    w_mouth = (w_ny_c >= G_TOP) && (w_ny_c <= G_BOT);

    // Box overlap against each paddle; uses the unclamped next position.
    w_dax   = $signed({w_nx[10], w_nx}) - $signed({2'b00, bus.paddle_a_x});
    w_day   = $signed({w_ny[10], w_ny}) - $signed({2'b00, bus.paddle_a_y});
    w_dbx   = $signed({w_nx[10], w_nx}) - $signed({2'b00, bus.paddle_b_x});
    w_dby   = $signed({w_ny[10], w_ny}) - $signed({2'b00, bus.paddle_b_y});
    w_hit_a = (fn_abs12(w_dax) <= REACH) && (fn_abs12(w_day) <= REACH);
    w_hit_b = (fn_abs12(w_dbx) <= REACH) && (fn_abs12(w_dby) <= REACH);

`ifdef PUCK_SPEEDUP_EN
    w_vmag = (w_avx >= VMAX) ? VMAX : w_avx + 5'sd1;
`else
    w_vmag = w_avx;
`endif
  end

  // Next-state / next-value logic for the whole game.
  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_vx_n    = r_vx;
    w_vy_n    = r_vy;
    w_sa_n    = r_sa;
    w_sb_n    = r_sb;
    w_dir_n   = r_dir;
    w_ysgn_n  = r_ysgn;
    w_hold_n  = r_hold;
    w_goal_n  = 1'b0;

    case (r_state)
      S_SERVE: begin
        w_x_n  = CX;
        w_y_n  = CY;
        w_vx_n = '0;
        w_vy_n = '0;
        // Serve wins over a coincident tick: no motion until the next tick.
        if (bus.serve) begin
          w_vx_n    = r_dir  ? -SPD : SPD;
          w_vy_n    = r_ysgn ? -SPD : SPD;
          w_ysgn_n  = ~r_ysgn;
          w_state_n = S_PLAY;
        end
      end

      S_PLAY: begin
        if (bus.frame_tick) begin
          w_y_n  = w_ny_c[9:0];
          w_vy_n = w_vy_b;
          if (w_nx <= LO) begin
            w_x_n = LO[9:0];
            if (w_mouth) begin
              w_sb_n    = (r_sb == WIN) ? r_sb : r_sb + 4'd1;
              w_goal_n  = 1'b1;
              w_dir_n   = 1'b0;
              w_vx_n    = '0;
              w_vy_n    = '0;
              w_state_n = S_HOLD;
            end else begin
              w_vx_n = w_avx;
            end
          end else if (w_nx >= X_HI) begin
            w_x_n = X_HI[9:0];
            if (w_mouth) begin
              w_sa_n    = (r_sa == WIN) ? r_sa : r_sa + 4'd1;
              w_goal_n  = 1'b1;
              w_dir_n   = 1'b1;
              w_vx_n    = '0;
              w_vy_n    = '0;
              w_state_n = S_HOLD;
            end else begin
              w_vx_n = -w_avx;
            end
          end else begin
            // Paddles only steer when no side wall was reached this frame.
            w_x_n = w_nx[9:0];
            if (w_hit_a)      w_vx_n = w_vmag;
            else if (w_hit_b) w_vx_n = -w_vmag;
          end
        end
      end

      S_HOLD: begin
        if (bus.frame_tick) begin
          if (r_hold == HOLD_LAST) begin
            w_hold_n  = '0;
            w_x_n     = CX;
            w_y_n     = CY;
            w_state_n = (r_sa == WIN || r_sb == WIN) ? S_OVER : S_SERVE;
          end else begin
            w_hold_n = r_hold + 1'b1;
          end
        end
      end

      S_OVER: begin
        w_x_n  = CX;
        w_y_n  = CY;
        w_vx_n = '0;
        w_vy_n = '0;
        if (bus.serve) begin
          w_sa_n    = '0;
          w_sb_n    = '0;
          w_dir_n   = 1'b0;
          w_ysgn_n  = 1'b0;
          w_hold_n  = '0;
          w_state_n = S_SERVE;
        end
      end

      default: w_state_n = S_SERVE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SERVE;
      r_x     <= CX;
      r_y     <= CY;
      r_vx    <= '0;
      r_vy    <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_dir   <= 1'b0;
      r_ysgn  <= 1'b0;
      r_hold  <= '0;
      r_goal  <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_vx    <= w_vx_n;
      r_vy    <= w_vy_n;
      r_sa    <= w_sa_n;
      r_sb    <= w_sb_n;
      r_dir   <= w_dir_n;
      r_ysgn  <= w_ysgn_n;
      r_hold  <= w_hold_n;
      r_goal  <= w_goal_n;
      r_over  <= (w_state_n == S_OVER);
    end
  end

  assign bus.puck_x    = r_x;
  assign bus.puck_y    = r_y;
  assign bus.score_a   = r_sa;
  assign bus.score_b   = r_sb;
  assign bus.goal      = r_goal;
  assign bus.game_over = r_over;
  assign bus.state     = r_state;

endmodule
